// File: rtl/occ_pkg.sv
// Shared definitions for the Occ lookup interface: widths, word/request types
// and the latency ceiling accepted by the responder.
package occ_pkg;

    localparam int unsigned OCC_ADDR_W      = 8;
    localparam int unsigned OCC_DATA_W      = 32;
    localparam int          OCC_MAX_LATENCY = 8;

    typedef logic [OCC_DATA_W-1:0] occ_word_t;

    typedef struct packed {
        logic                  valid;
        logic [OCC_ADDR_W-1:0] addr;
    } occ_req_t;

endpackage

// File: rtl/occ_delay_line.sv
// Valid+data shift register of DEPTH stages with synchronous clear of the
// valid bits. DEPTH=0 passes the input straight through.
module occ_delay_line
    import occ_pkg::*;
#(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = OCC_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_stages
        logic              v [DEPTH];
        logic [DATA_W-1:0] d [DEPTH];

        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_first
                // First stage captures the incoming word; clear drops its valid
                always_ff @(posedge clk) begin
                    v[0] <= clr ? 1'b0 : in_valid;
                    d[0] <= in_data;
                end
            end else begin : g_next
                // Later stages shift the previous stage forward
                always_ff @(posedge clk) begin
                    v[g] <= clr ? 1'b0 : v[g-1];
                    d[g] <= d[g-1];
                end
            end
        end

        assign out_valid = v[DEPTH-1];
        assign out_data  = d[DEPTH-1];
    end

endmodule

// File: rtl/occ_mem_responder.sv
// Occ lookup responder: externally loaded word memory answering ce_i/addr_i
// requests in order with a fixed LATENCY and a one-cycle data_valid_o strobe.
// Optional feature macro: OCC_RESP_HOLD_EN (data_o holds the last returned
// word between returns instead of reading zero).
module occ_mem_responder
    import occ_pkg::*;
#(
    parameter int unsigned ADDR_W  = OCC_ADDR_W,
    parameter int unsigned DATA_W  = OCC_DATA_W,
    parameter int          LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [3:0]        outstanding_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i
);

    if (LATENCY < 1 || LATENCY > OCC_MAX_LATENCY) begin : g_bad_latency
        $error("occ_mem_responder: LATENCY must be within 1..8");
    end

    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              accept;
    logic [DATA_W-1:0] rd_data;
    logic              dl_valid;
    logic [DATA_W-1:0] dl_data;

    assign accept  = ce_i & ~rst;
    // Combinational read in the acceptance cycle yields the pre-write word on
    // a same-address load, giving read-before-write ordering.
    assign rd_data = mem[addr_i];

    // Load port; memory is deliberately outside reset
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    occ_delay_line #(
        .DEPTH  (LATENCY - 1),
        .DATA_W (DATA_W)
    ) u_delay (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (accept),
        .in_data   (rd_data),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    // Final registered stage driving the response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid_o <= 1'b0;
            data_o       <= '0;
        end else begin
            data_valid_o <= dl_valid;
`ifdef OCC_RESP_HOLD_EN
            if (dl_valid) begin
                data_o <= dl_data;
            end
`else
            data_o <= dl_valid ? dl_data : '0;
`endif
        end
    end

    // In-flight count: a request stays counted through its data_valid_o cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_o <= '0;
        end else begin
            case ({accept, data_valid_o})
                2'b10:   outstanding_o <= outstanding_o + 4'd1;
                2'b01:   outstanding_o <= outstanding_o - 4'd1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

endmodule

// File: doc/occ_mem_responder.md
# occ_mem_responder

Responder end of the Occ lookup interface driven by the accelerator FSM: accepts `ce`/address requests, reads a 32-bit Occ word from an internal, externally loaded memory, and returns it with a `data_valid` strobe a fixed number of cycles later. It sits beside `accelerator_top` and takes the place of a bare ROM. Its fixed latency exercises the FSM's wait-for-`data_valid` path. Contents are written before a run through a random-write load port, in the same way as the regfile initial data.

## Interface
Parameters:
- `ADDR_W`, 8: request/load address width; depth = 2^ADDR_W.
- `DATA_W`, 32: Occ word width.
- `LATENCY`, 2: cycles from accepted request to `data_valid_o`. Legal range 1..8; elaboration error outside it.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce_i` in 1: request strobe; one request per cycle high.
- `addr_i` in ADDR_W: request address, sampled when `ce_i`=1.
- `data_o` out DATA_W: returned Occ word.
- `data_valid_o` out 1: `data_o` is valid this cycle (one-cycle pulse per request).
- `outstanding_o` out 4: requests accepted but not yet returned.
- `load_we_i` in 1: memory write enable.
- `load_addr_i` in ADDR_W: write address.
- `load_data_i` in DATA_W: write data.

## Operation
- Fully pipelined. A request is accepted every cycle `ce_i`=1 with no backpressure. Responses come back in order, exactly one per request.
- Memory read happens in the acceptance cycle. The word is then carried through a (LATENCY-1)-deep valid/data delay line, and the last stage drives `data_o`/`data_valid_o` from registers.
- Load write and request in the same cycle to the same address: the request returns the old word (read-before-write). Different addresses: both take effect.
- Loads are allowed at any time, including while requests are in flight. In-flight words are unaffected.
- `outstanding_o` tracks requests in flight:
  - +1 on accept, -1 on return, unchanged when both happen in the same cycle.
  - Max value is LATENCY.
- Memory contents are not cleared by `rst`.
- Reset values: `data_valid_o`=0, `data_o`=0, `outstanding_o`=0. All delay-line valid bits are cleared.

## Timing
- Request accepted at edge N (`ce_i`=1 sampled) → `data_valid_o`=1 during the cycle after edge N+LATENCY-1. Example: LATENCY=2, request sampled at edge 0 → data visible after edge 1.
- Back-to-back requests on consecutive cycles → `data_valid_o` high on consecutive cycles, in the same order.
- Load written at edge N is visible to a request sampled at edge N+1 or later.
- `rst` asserted mid-operation: all in-flight requests are dropped. No `data_valid_o` pulse from a pre-reset request may appear after the reset edge. `outstanding_o`=0 on the cycle after the reset edge. A `ce_i` sampled in the same cycle as `rst` is ignored.
- `ce_i` while `rst`=1: ignored. `load_we_i` while `rst`=1: performed, since memory is not under reset.

## Configuration
- `OCC_RESP_HOLD_EN` defined: `data_o` holds the last returned word while `data_valid_o`=0. It reads 0 only after reset until the first return.
- `OCC_RESP_HOLD_EN` not defined: `data_o` is forced to 0 in every cycle where `data_valid_o`=0.
- `data_valid_o` and `outstanding_o` behave identically in both builds.

## Structure
- Shared package `occ_pkg`:
  - `OCC_ADDR_W`=8, `OCC_DATA_W`=32.
  - typedef `occ_word_t`.
  - typedef `occ_req_t` (valid, addr).
  - `OCC_MAX_LATENCY`=8.
- One sub-module, `occ_delay_line`: a parameterized valid+data shift register of depth LATENCY-1 with synchronous clear. LATENCY=1 degenerates it to wires.
- The memory is a plain register array inferred in the top; there is no separate module.

## Test plan
- Load `addr 0x05`=`0xDEADBEEF`, then one request to `0x05` with LATENCY=2 → one `data_valid_o` pulse exactly 2 cycles after the request, `data_o`=`0xDEADBEEF`. `outstanding_o` goes 1 and then back to 0.
- Load addr 0..3 with `0x10..0x13`, then four back-to-back requests 3,0,2,1 → four consecutive valid cycles returning `0x13, 0x10, 0x12, 0x11`. `outstanding_o` peaks at 2.
- Same-cycle load `0x07`=`0xAAAA0000` (old `0x12345678`) and request `0x07` → returns `0x12345678`. A request on the next cycle returns `0xAAAA0000`.
- Two requests in flight, `rst` pulsed for one cycle → no `data_valid_o` afterwards, `outstanding_o`=0, `data_o`=0. Memory contents are intact on a subsequent read.
- Sweep LATENCY=1, 4, 8 with a single request → valid after exactly 1, 4, 8 cycles.
- Build with and without `OCC_RESP_HOLD_EN`, return `0xCAFEF00D` and idle 3 cycles → `data_o` stays `0xCAFEF00D` with the macro, and is 0 without it.
